// File: rtl/rom_dumper_pkg.sv
// rtl/rom_dumper_pkg.sv - shared system constants for the programmer and ROM dumper
package rom_dumper_pkg;

  // Host command bytes understood on the debug UART
  localparam logic [7:0] CMD_PROG_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_PROG_ERASE = 8'h45;  // 'E'
  localparam logic [7:0] CMD_ROM_DUMP   = 8'h52;  // 'R'

  // Running byte checksum, wraps modulo 256
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/rom_dumper.sv
// rtl/rom_dumper.sv - streams ROM words over the UART on request, holding the CPU in reset
module rom_dumper
  import rom_dumper_pkg::*;
#(
  parameter int         ADDR_WIDTH = 14,
  parameter logic [7:0] CMD_BYTE   = CMD_ROM_DUMP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_tick,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_ren,
  input  logic [31:0]           rom_rdata,
  output logic                  hold_rst
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CNT_LO  = 3'd1,
    CNT_HI  = 3'd2,
    READ    = 3'd3,
    RD_WAIT = 3'd4,
    SEND    = 3'd5,
    CHK     = 3'd6
  } state_t;

  // Wide enough to hold both the 16-bit count and 2^ADDR_WIDTH
  localparam int EW = (ADDR_WIDTH >= 16) ? ADDR_WIDTH + 1 : 17;

  state_t                r_state;
  state_t                w_next;
  logic [7:0]            r_count_lo;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_last;
  logic [31:0]           r_shift;
  logic [1:0]            r_idx;
  logic [7:0]            r_csum;
  logic [7:0]            r_tx_data;
  logic                  r_tx_start;
  logic                  r_hold;

  logic                  w_can_tx;
  logic                  w_emit;
  logic                  w_emit_data;
  logic [7:0]            w_emit_byte;
  logic                  w_ld_lo;
  logic                  w_ld_hi;
  logic                  w_latch;
  logic                  w_adv;
  logic [15:0]           w_count;
  logic [EW-1:0]         w_n;
  logic [EW-1:0]         w_n_m1;
  logic [EW-1:0]         w_max;
  logic [ADDR_WIDTH-1:0] w_last_addr;

  // The cycle after a tx_start the transmitter may not yet show busy, so wait one extra cycle
  assign w_can_tx = !tx_busy && !r_tx_start;

  assign w_count  = {rx_data, r_count_lo};
  assign w_n      = EW'(w_count);
  assign w_n_m1   = w_n - EW'(1);
  assign w_max    = EW'(1) << ADDR_WIDTH;

  // Last word address: zero or oversized counts dump the whole ROM
  always_comb begin
    w_last_addr = {ADDR_WIDTH{1'b1}};
    if ((w_n != '0) && (w_n <= w_max))
      w_last_addr = w_n_m1[ADDR_WIDTH-1:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    w_next      = r_state;
    w_emit      = 1'b0;
    w_emit_data = 1'b0;
    w_emit_byte = 8'h00;
    w_ld_lo     = 1'b0;
    w_ld_hi     = 1'b0;
    w_latch     = 1'b0;
    w_adv       = 1'b0;
    case (r_state)
      IDLE: begin
        if (rx_tick && (rx_data == CMD_BYTE)) w_next = CNT_LO;
      end
      CNT_LO: begin
        if (rx_tick) begin
          w_ld_lo = 1'b1;
          w_next  = CNT_HI;
        end
      end
      CNT_HI: begin
        if (rx_tick) begin
          w_ld_hi = 1'b1;
          w_next  = READ;
        end
      end
      READ: begin
        w_next = RD_WAIT;
      end
      RD_WAIT: begin
        w_latch = 1'b1;
        w_next  = SEND;
      end
      SEND: begin
        if (w_can_tx) begin
          w_emit      = 1'b1;
          w_emit_data = 1'b1;
          w_emit_byte = r_shift[7:0];
          if (r_idx == 2'd3) begin
            if (r_addr == r_last) begin
              w_next = CHK;
            end else begin
              w_adv  = 1'b1;
              w_next = READ;
            end
          end
        end
      end
      CHK: begin
        if (w_can_tx) begin
          w_emit      = 1'b1;
          w_emit_byte = r_csum;
          w_next      = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath: count, address, word shifter, checksum, transmit and hold registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count_lo <= 8'h00;
      r_addr     <= '0;
      r_last     <= '0;
      r_shift    <= 32'h0;
      r_idx      <= 2'd0;
      r_csum     <= 8'h00;
      r_tx_data  <= 8'h00;
      r_tx_start <= 1'b0;
      r_hold     <= 1'b0;
    end else begin
      r_tx_start <= w_emit;
      if (w_emit) r_tx_data <= w_emit_byte;
      if (w_ld_lo) r_count_lo <= rx_data;
      if (w_ld_hi) begin
        r_last <= w_last_addr;
        r_addr <= '0;
        r_csum <= 8'h00;
        r_hold <= 1'b1;
      end else if ((r_state == IDLE) && r_tx_start) begin
        // Only the checksum byte leaves a tx_start pending while back in IDLE
        r_hold <= 1'b0;
      end
      if (w_latch) begin
        r_shift <= rom_rdata;
        r_idx   <= 2'd0;
      end else if (w_emit_data) begin
        r_shift <= {8'h00, r_shift[31:8]};
        r_idx   <= r_idx + 2'd1;
        r_csum  <= csum_add(r_csum, r_shift[7:0]);
      end
      if (w_adv) r_addr <= r_addr + ADDR_WIDTH'(1);
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_start = r_tx_start;
  assign rom_addr = r_addr;
  assign rom_ren  = (r_state == READ);
  assign hold_rst = r_hold;

endmodule
